// File: rtl/i2s_stereo_xcvr.sv
// ---------------------------------------------------------------------------
// i2s_stereo_xcvr
// Full-duplex stereo I2S slave transceiver. The external bclk/lrclk pair is
// oversampled in the clk domain (clk >= 8x bclk). One serial RX lane and one
// serial TX lane, with a valid/ready handshake on each parallel side.
//
// Optional feature macro: I2S_ERR_EN adds the sticky tx_urun / rx_ovr flags
// and the err_clr input. Without it those ports and their logic are absent.
//
// Ports
//   clk, rstn          system clock, async active-low reset
//   enable             low forces IDLE and clears all frame state
//   delay[4:0]         bit positions between lrclk edge and MSB
//   bclk, lrclk, rx    async serial inputs (lrclk=0 left, 1 right)
//   tx                 serial data out
//   tx_l, tx_r         TX samples; tx_valid / tx_ready handshake
//   rx_l, rx_r         RX samples; rx_valid / rx_ready handshake
//   tx_urun, rx_ovr    sticky error flags (I2S_ERR_EN only)
//   err_clr            clears both flags (I2S_ERR_EN only)
// ---------------------------------------------------------------------------
module i2s_stereo_xcvr #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic [4:0]    delay,
    input  logic          bclk,
    input  logic          lrclk,
    input  logic          rx,
    output logic          tx,
    input  logic [DW-1:0] tx_l,
    input  logic [DW-1:0] tx_r,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_l,
    output logic [DW-1:0] rx_r,
    output logic          rx_valid,
    input  logic          rx_ready
`ifdef I2S_ERR_EN
    ,
    output logic          tx_urun,
    output logic          rx_ovr,
    input  logic          err_clr
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [6:0] DW7 = 7'(DW);

    state_t        state_r, state_nx_s;
    logic [2:0]    bclk_pipe_r;
    logic [1:0]    lr_pipe_r;
    logic [1:0]    rx_pipe_r;
    logic [5:0]    cnt_r;
    logic          lr_prev_r;
    logic [DW-1:0] rx_sh_r;
    logic [DW-1:0] left_stage_r;
    logic          left_ok_r;
    logic [DW-1:0] hold_l_r, hold_r_r;
    logic          hold_full_r;
    logic [DW-1:0] sh_l_r, sh_r_r;
    logic          tx_on_r;

    logic          rise_s, fall_s, lr_s, rx_s, act_s;
    logic          lr_chg_s, left_start_rise_s;
    logic [5:0]    cnt_inc_s, cnt_nx_s, p_s;
    logic [6:0]    win_lo_s, win_end_s, off_s, idx_s;
    logic          in_win_rx_s, last_rx_s, in_win_tx_s;
    logic [DW-1:0] rx_word_s;
    logic          done_right_s;
    logic          xfer_s, tx_hs_s, hold_full_nx_s, tx_on_nx_s;
    logic [DW-1:0] src_l_s, src_r_s, src_word_s, shifted_s;
    logic          tx_bit_s;

    // Edge detection and position arithmetic shared by the RX and TX paths.
    always_comb begin
        rise_s            = bclk_pipe_r[1] & ~bclk_pipe_r[2];
        fall_s            = ~bclk_pipe_r[1] & bclk_pipe_r[2];
        lr_s              = lr_pipe_r[1];
        rx_s              = rx_pipe_r[1];
        act_s             = (state_r != ST_IDLE);
        lr_chg_s          = (lr_s != lr_prev_r);
        left_start_rise_s = rise_s && !lr_s && lr_prev_r;
        cnt_inc_s         = (cnt_r == 6'd63) ? 6'd63 : cnt_r + 6'd1;
        // A changed lrclk at either edge means position 0 of the new slot.
        cnt_nx_s          = lr_chg_s ? 6'd0 : cnt_inc_s;
        p_s               = lr_chg_s ? 6'd0 : cnt_inc_s;
        win_lo_s          = {2'b00, delay};
        win_end_s         = win_lo_s + DW7;
        in_win_rx_s       = ({1'b0, cnt_nx_s} >= win_lo_s) && ({1'b0, cnt_nx_s} < win_end_s);
        last_rx_s         = ({1'b0, cnt_nx_s} == (win_end_s - 7'd1));
        in_win_tx_s       = ({1'b0, p_s} >= win_lo_s) && ({1'b0, p_s} < win_end_s);
        off_s             = {1'b0, p_s} - win_lo_s;
        idx_s             = DW7 - 7'd1 - off_s;
        rx_word_s         = {rx_sh_r[DW-2:0], rx_s};
        done_right_s      = rise_s && (state_r == ST_RUN) && last_rx_s && lr_s && left_ok_r;
        // A left slot starts at the fall where lrclk goes 1->0.
        xfer_s            = fall_s && act_s && !lr_s && lr_prev_r;
        tx_hs_s           = tx_valid && tx_ready;
        tx_on_nx_s        = tx_on_r | xfer_s;
        src_l_s           = xfer_s ? (hold_full_r ? hold_l_r : {DW{1'b0}}) : sh_l_r;
        src_r_s           = xfer_s ? (hold_full_r ? hold_r_r : {DW{1'b0}}) : sh_r_r;
        src_word_s        = lr_s ? src_r_s : src_l_s;
        shifted_s         = src_word_s >> idx_s;
        tx_bit_s          = shifted_s[0];
        if (!enable) begin
            hold_full_nx_s = 1'b0;
        end else if (tx_hs_s) begin
            hold_full_nx_s = 1'b1;
        end else if (xfer_s) begin
            hold_full_nx_s = 1'b0;
        end else begin
            hold_full_nx_s = hold_full_r;
        end
    end

    // Next-state logic: enable low overrides every state.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nx_s = ST_SYNC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (left_start_rise_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_SYNC;
                end
            end
            ST_RUN:  state_nx_s = ST_RUN;
            default: state_nx_s = ST_IDLE;
        endcase
        if (!enable) begin
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Two-flop synchronisers plus the bclk edge-detect stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bclk_pipe_r <= 3'b000;
            lr_pipe_r   <= 2'b00;
            rx_pipe_r   <= 2'b00;
        end else begin
            bclk_pipe_r <= {bclk_pipe_r[1:0], bclk};
            lr_pipe_r   <= {lr_pipe_r[0], lrclk};
            rx_pipe_r   <= {rx_pipe_r[0], rx};
        end
    end

    // Slot position counter and RX deserialiser, advanced on bclk rise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r        <= 6'd0;
            lr_prev_r    <= 1'b0;
            rx_sh_r      <= {DW{1'b0}};
            left_stage_r <= {DW{1'b0}};
            left_ok_r    <= 1'b0;
            rx_l         <= {DW{1'b0}};
            rx_r         <= {DW{1'b0}};
            rx_valid     <= 1'b0;
        end else if (!enable) begin
            cnt_r        <= 6'd0;
            lr_prev_r    <= 1'b0;
            rx_sh_r      <= {DW{1'b0}};
            left_stage_r <= {DW{1'b0}};
            left_ok_r    <= 1'b0;
            rx_valid     <= 1'b0;
        end else begin
            if (rise_s && act_s) begin
                cnt_r     <= cnt_nx_s;
                lr_prev_r <= lr_s;
                if (in_win_rx_s) begin
                    rx_sh_r <= rx_word_s;
                end else begin
                    rx_sh_r <= rx_sh_r;
                end
                // A left word that never completed must not pair with a right word.
                if (left_start_rise_s) begin
                    left_ok_r <= 1'b0;
                end else if (last_rx_s && (state_r == ST_RUN) && !lr_s) begin
                    left_stage_r <= rx_word_s;
                    left_ok_r    <= 1'b1;
                end else if (done_right_s) begin
                    left_ok_r <= 1'b0;
                end else begin
                    left_ok_r <= left_ok_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
            // A fresh frame beats a same-cycle handshake.
            if (done_right_s) begin
                rx_l     <= left_stage_r;
                rx_r     <= rx_word_s;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

    // TX holding register, shifter and serial output, advanced on bclk fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_l_r    <= {DW{1'b0}};
            hold_r_r    <= {DW{1'b0}};
            hold_full_r <= 1'b0;
            sh_l_r      <= {DW{1'b0}};
            sh_r_r      <= {DW{1'b0}};
            tx_on_r     <= 1'b0;
            tx          <= 1'b0;
            tx_ready    <= 1'b0;
        end else if (!enable) begin
            hold_full_r <= 1'b0;
            sh_l_r      <= {DW{1'b0}};
            sh_r_r      <= {DW{1'b0}};
            tx_on_r     <= 1'b0;
            tx          <= 1'b0;
            tx_ready    <= 1'b0;
        end else begin
            if (xfer_s) begin
                sh_l_r <= src_l_s;
                sh_r_r <= src_r_s;
            end else begin
                sh_l_r <= sh_l_r;
            end
            if (tx_hs_s) begin
                hold_l_r <= tx_l;
                hold_r_r <= tx_r;
            end else begin
                hold_l_r <= hold_l_r;
            end
            hold_full_r <= hold_full_nx_s;
            tx_on_r     <= tx_on_nx_s;
            tx_ready    <= (state_nx_s != ST_IDLE) && !hold_full_nx_s;
            if (fall_s && act_s) begin
                tx <= tx_on_nx_s && in_win_tx_s && tx_bit_s;
            end else begin
                tx <= tx;
            end
        end
    end

`ifdef I2S_ERR_EN
    logic urun_set_s, ovr_set_s;

    // Error-flag set conditions.
    always_comb begin
        urun_set_s = xfer_s && !hold_full_r;
        ovr_set_s  = done_right_s && rx_valid && !rx_ready;
    end

    // Sticky error flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_urun <= 1'b0;
            rx_ovr  <= 1'b0;
        end else if (!enable) begin
            tx_urun <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            if (urun_set_s) begin
                tx_urun <= 1'b1;
            end else if (err_clr) begin
                tx_urun <= 1'b0;
            end else begin
                tx_urun <= tx_urun;
            end
            if (ovr_set_s) begin
                rx_ovr <= 1'b1;
            end else if (err_clr) begin
                rx_ovr <= 1'b0;
            end else begin
                rx_ovr <= rx_ovr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2s_stereo_xcvr.sv
// ---------------------------------------------------------------------------
// tb_i2s_stereo_xcvr
// Directed bench: an I2S master model drives bclk/lrclk/rx with 32-bit slots
// (bclk = clk/16) into a DW=16 and a DW=24 transceiver, and captures tx.
// Slot patterns and expected words are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_i2s_stereo_xcvr;

    logic        clk = 1'b0;
    logic        rstn, enable, bclk, lrclk, rx, tx_valid, err_clr;
    logic [4:0]  delay16, delay24;
    logic [15:0] tx_l16, tx_r16;
    logic [23:0] tx_l24, tx_r24;
    logic        rx_ready16, rx_ready24;
    logic        tx16, tx24, tx_ready16, tx_ready24, rx_valid16, rx_valid24;
    logic [15:0] rx_l16, rx_r16;
    logic [23:0] rx_l24, rx_r24;
    logic        urun16, ovr16, urun24, ovr24;
    logic [63:0] c16, c24;
    logic [31:0] d16, d24;
    int          tests = 0;
    int          fails = 0;
    int          hs16  = 0;

    always #5 clk = ~clk;

    i2s_stereo_xcvr #(.DW(16)) u16 (
        .clk(clk), .rstn(rstn), .enable(enable), .delay(delay16),
        .bclk(bclk), .lrclk(lrclk), .rx(rx), .tx(tx16),
        .tx_l(tx_l16), .tx_r(tx_r16), .tx_valid(tx_valid), .tx_ready(tx_ready16),
        .rx_l(rx_l16), .rx_r(rx_r16), .rx_valid(rx_valid16), .rx_ready(rx_ready16)
`ifdef I2S_ERR_EN
        , .tx_urun(urun16), .rx_ovr(ovr16), .err_clr(err_clr)
`endif
    );

    i2s_stereo_xcvr #(.DW(24)) u24 (
        .clk(clk), .rstn(rstn), .enable(enable), .delay(delay24),
        .bclk(bclk), .lrclk(lrclk), .rx(rx), .tx(tx24),
        .tx_l(tx_l24), .tx_r(tx_r24), .tx_valid(tx_valid), .tx_ready(tx_ready24),
        .rx_l(rx_l24), .rx_r(rx_r24), .rx_valid(rx_valid24), .rx_ready(rx_ready24)
`ifdef I2S_ERR_EN
        , .tx_urun(urun24), .rx_ovr(ovr24), .err_clr(err_clr)
`endif
    );

`ifndef I2S_ERR_EN
    assign urun16 = 1'b0;
    assign ovr16  = 1'b0;
    assign urun24 = 1'b0;
    assign ovr24  = 1'b0;
`endif

    // Count RX handshakes on the DW=16 instance.
    always @(posedge clk) begin
        if (rx_valid16 && rx_ready16) begin
            hs16 <= hs16 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One slot, bits first..last; lrclk/rx change at bclk fall, tx sampled late in the high phase.
    task automatic slot(input logic lr, input logic [31:0] w, input int first, input int last,
                        output logic [31:0] t16, output logic [31:0] t24);
        t16 = 32'h0;
        t24 = 32'h0;
        for (int b = first; b <= last; b++) begin
            bclk  = 1'b0;
            lrclk = lr;
            rx    = w[31-b];
            repeat (8) @(negedge clk);
            bclk = 1'b1;
            repeat (7) @(negedge clk);
            t16[31-b] = tx16;
            t24[31-b] = tx24;
            @(negedge clk);
        end
    endtask

    task automatic frame(input logic [31:0] lw, input logic [31:0] rw,
                         output logic [63:0] f16, output logic [63:0] f24);
        logic [31:0] a16, a24, b16, b24;
        slot(1'b0, lw, 0, 31, a16, a24);
        slot(1'b1, rw, 0, 31, b16, b24);
        f16 = {a16, b16};
        f24 = {a24, b24};
    endtask

    task automatic load_tx;
        @(negedge clk);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; bclk = 1'b1; lrclk = 1'b1; rx = 1'b0;
        tx_valid = 1'b0; err_clr = 1'b0; delay16 = 5'd1; delay24 = 5'd0;
        rx_ready16 = 1'b1; rx_ready24 = 1'b1;
        tx_l16 = 16'hA5C3; tx_r16 = 16'h0FF0; tx_l24 = 24'h123456; tx_r24 = 24'hFEDCBA;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", 64'(tx16), 64'h0);
        check("reset_rx_valid", 64'(rx_valid16), 64'h0);
        check("reset_tx_ready", 64'(tx_ready16), 64'h0);
        check("reset_rx_l", 64'(rx_l16), 64'h0);
        check("reset_rx_r", 64'(rx_r16), 64'h0);

        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("sync_tx_ready16", 64'(tx_ready16), 64'h1);
        check("sync_tx_ready24", 64'(tx_ready24), 64'h1);
        load_tx;
        check("loaded_tx_ready16", 64'(tx_ready16), 64'h0);

        // Preamble in a right slot, then frame 1: L=0x8001 R=0x7FFE at delay 1.
        slot(1'b1, 32'h0, 0, 3, d16, d24);
        frame(32'h40008000, 32'h3FFF0000, c16, c24);
        check("f1_handshakes", 64'(hs16), 64'd1);
        check("f1_rx_l", 64'(rx_l16), 64'h8001);
        check("f1_rx_r", 64'(rx_r16), 64'h7FFE);
        check("f1_tx16", c16, 64'h52E18000_07F80000);
        check("f1_tx24", c24, 64'h12345600_FEDCBA00);
        check("f1_tx_ready16", 64'(tx_ready16), 64'h1);

        // Frame 2: nothing loaded -> zero frame.
        frame(32'h091A0000, 32'h55E68000, c16, c24);
        check("f2_handshakes", 64'(hs16), 64'd2);
        check("f2_rx_l", 64'(rx_l16), 64'h1234);
        check("f2_rx_r", 64'(rx_r16), 64'hABCD);
        check("f2_tx16_zero", c16, 64'h0);
        check("f2_tx24_zero", c24, 64'h0);
`ifdef I2S_ERR_EN
        check("f2_tx_urun", 64'(urun16), 64'h1);
`endif

        // Frames 3 and 4 with rx_ready low -> overwrite.
        rx_ready16 = 1'b0;
        frame(32'h08888000, 32'h11110000, c16, c24);
        frame(32'h19998000, 32'h22220000, c16, c24);
        check("ovr_rx_valid", 64'(rx_valid16), 64'h1);
        check("ovr_rx_l", 64'(rx_l16), 64'h3333);
        check("ovr_rx_r", 64'(rx_r16), 64'h4444);
        check("ovr_no_handshake", 64'(hs16), 64'd2);
`ifdef I2S_ERR_EN
        check("ovr_flag", 64'(ovr16), 64'h1);
`endif
        rx_ready16 = 1'b1;
        repeat (4) @(negedge clk);
        check("ovr_one_handshake", 64'(hs16), 64'd3);
        check("ovr_valid_cleared", 64'(rx_valid16), 64'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
`ifdef I2S_ERR_EN
        check("clr_tx_urun", 64'(urun16), 64'h0);
        check("clr_rx_ovr", 64'(ovr16), 64'h0);
`endif

        // Frame 5: enable dropped mid right slot.
        slot(1'b0, 32'h40008000, 0, 31, d16, d24);
        slot(1'b1, 32'h3FFF0000, 0, 9, d16, d24);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_tx", 64'(tx16), 64'h0);
        check("drop_rx_valid", 64'(rx_valid16), 64'h0);
        check("drop_tx_ready", 64'(tx_ready16), 64'h0);
        enable = 1'b1;
        slot(1'b1, 32'h3FFF0000, 10, 31, d16, d24);
        check("drop_no_partial", 64'(hs16), 64'd3);
        frame(32'h07878000, 32'h78780000, c16, c24);
        check("resync_handshakes", 64'(hs16), 64'd4);
        check("resync_rx_l", 64'(rx_l16), 64'h0F0F);
        check("resync_rx_r", 64'(rx_r16), 64'hF0F0);

        // Frame 7: delay 20 truncates both directions.
        delay16 = 5'd20;
        tx_l16 = 16'hFFFF;
        tx_r16 = 16'hFFFF;
        check("trunc_tx_ready", 64'(tx_ready16), 64'h1);
        load_tx;
        frame(32'hFFFFFFFF, 32'hFFFFFFFF, c16, c24);
        check("trunc_no_rx", 64'(hs16), 64'd4);
        check("trunc_tx16", c16, 64'h00000FFF_00000FFF);

        // Frame 8: back to delay 1, lane still alive.
        delay16 = 5'd1;
        frame(32'h40008000, 32'h3FFF0000, c16, c24);
        check("recover_handshakes", 64'(hs16), 64'd5);
        check("recover_rx_l", 64'(rx_l16), 64'h8001);
        check("recover_rx_r", 64'(rx_r16), 64'h7FFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
